// File: rtl/aes_256_sched.sv
// aes_256_sched: round-robin request scheduler and in-order result tracker for an unstallable aes_256 core
// Ports: req_* valid/ready requesters (state+key each), core_state/core_key registered to core, core_out ciphertext back,
//        rsp_* output FIFO head (data + requester id), inflight/fifo_count occupancy.
module aes_256_sched #(
  parameter int NREQ = 4,
  parameter int LATENCY = 30,
  parameter int FIFO_DEPTH = 32,
  parameter int ID_W = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ*128-1:0]              req_state,
  input  logic [NREQ*256-1:0]              req_key,
  output logic [NREQ-1:0]                  req_ready,
  output logic [127:0]                     core_state,
  output logic [255:0]                     core_key,
  input  logic [127:0]                     core_out,
  output logic                             rsp_valid,
  output logic [127:0]                     rsp_data,
  output logic [ID_W-1:0]                  rsp_id,
  input  logic                             rsp_ready,
  output logic [$clog2(LATENCY+1)-1:0]     inflight,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
  localparam int IW = $clog2(LATENCY+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(NREQ);
  logic [ID_W-1:0] ptr_q, gnt_id;
  logic [SW-1:0] j;
  logic [NREQ-1:0] win;
  logic found, can_issue, hs, cap, push, pop, full, ovf_q;
  logic [LATENCY-1:0] sv_q;
  logic [LATENCY-1:0][ID_W-1:0] sid_q;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, rd_q;
  logic [ID_W+127:0] mem_q [FIFO_DEPTH];
  logic [127:0] state_q;
  logic [255:0] key_q;
  // first valid requester after the last winner
  always_comb begin
    win = '0;
    found = 1'b0;
    gnt_id = '0;
    j = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = SW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[j]) begin
        found = 1'b1;
        win[j] = 1'b1;
        gnt_id = ID_W'(j);
      end
    end
  end
  // credit counts blocks in the core as already occupying a FIFO slot, since the core cannot stall
  assign can_issue = int'(inflight_q) + int'(cnt_q) < FIFO_DEPTH;
  assign req_ready = (rst || !can_issue) ? '0 : win;
  assign hs = |req_ready;
  assign cap = sv_q[LATENCY-1];
  assign full = cnt_q == CW'(FIFO_DEPTH);
  assign rsp_valid = cnt_q != '0;
  assign pop = rsp_valid & rsp_ready;
  assign push = cap & (~full | pop);
  assign rsp_data = rsp_valid ? mem_q[rd_q][127:0] : '0;
  assign rsp_id = rsp_valid ? mem_q[rd_q][ID_W+127:128] : '0;
  assign inflight_d = hs == cap ? inflight_q : hs ? inflight_q + IW'(1) : inflight_q - IW'(1);
  assign cnt_d = push == pop ? cnt_q : push ? cnt_q + CW'(1) : cnt_q - CW'(1);
  assign inflight = inflight_q;
  assign fifo_count = cnt_q;
  assign core_state = state_q;
  assign core_key = key_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q <= ID_W'(NREQ-1);
      sv_q <= '0;
      sid_q <= '0;
      inflight_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      state_q <= '0;
      key_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sv_q <= {sv_q[LATENCY-2:0], hs};
      sid_q <= {sid_q[LATENCY-2:0], gnt_id};
      if (hs) begin
        ptr_q <= gnt_id;
        state_q <= req_state[128*gnt_id +: 128];
        key_q <= req_key[256*gnt_id +: 256];
      end
      if (push) wr_q <= wr_q + PW'(1);
      if (pop) rd_q <= rd_q + PW'(1);
      if (cap && !push) ovf_q <= 1'b1;
      inflight_q <= inflight_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {sid_q[LATENCY-1], core_out};
  // a dropped result means the credit accounting is broken
  always_ff @(posedge clk)
    assert (!ovf_q);
endmodule

// File: tb/tb_aes_256_sched.sv
module tb_aes_256_sched;
  localparam int NREQ = 4, L = 30, FD = 32, IDW = 2;
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FKEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FCT = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic clk = 0, rst = 1, rsp_ready = 0;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*128-1:0] req_state = '0;
  logic [NREQ*256-1:0] req_key = '0;
  logic [127:0] core_state, core_out, rsp_data;
  logic [255:0] core_key;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [4:0] inflight;
  logic [5:0] fifo_count;
  aes_256_sched #(.NREQ(NREQ), .LATENCY(L), .FIFO_DEPTH(FD), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_state(req_state), .req_key(req_key),
    .req_ready(req_ready), .core_state(core_state), .core_key(core_key), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .inflight(inflight), .fifo_count(fifo_count));
  always #5 clk = ~clk;
  // stand-in core: the known AES-256 vector, otherwise a cheap keyed mix
  function automatic logic [127:0] aes_stub(input logic [127:0] s, input logic [255:0] k);
    return (s == FPT && k == FKEY) ? FCT : s ^ k[127:0] ^ {k[191:128], k[255:192]};
  endfunction
  logic [127:0] cpipe [L-1];
  always @(posedge clk) begin
    cpipe[0] <= aes_stub(core_state, core_key);
    for (int k = 1; k < L-1; k++) cpipe[k] <= cpipe[k-1];
  end
  assign core_out = cpipe[L-2];
  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  logic [127+IDW:0] exp_q [$];
  logic [127+IDW:0] e;
  logic [NREQ-1:0] hs_last = '0;
  int g_log [$];
  int hs_total = 0;
  always @(negedge clk) begin
    hs_last = req_valid & req_ready;
    if (rst) exp_q.delete();
    else begin
      for (int i = 0; i < NREQ; i++)
        if (hs_last[i]) begin
          exp_q.push_back({IDW'(i), aes_stub(req_state[128*i +: 128], req_key[256*i +: 256])});
          g_log.push_back(i);
          hs_total++;
        end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected: got id %0d data %h, expected no response", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", rsp_data, e[127:0]);
          check("sb_id", rsp_id, e[127+IDW:128]);
        end
      end
    end
  end
  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic refresh();
    for (int i = 0; i < NREQ; i++)
      if (hs_last[i]) begin
        req_state[128*i +: 128] = r128();
        req_key[256*i +: 256] = {r128(), r128()};
      end
  endtask
  task automatic all_valid();
    for (int i = 0; i < NREQ; i++) begin
      req_state[128*i +: 128] = r128();
      req_key[256*i +: 256] = {r128(), r128()};
    end
    req_valid = '1;
  endtask
  task automatic drain();
    int c = 0;
    req_valid = '0;
    rsp_ready = 1;
    while ((inflight != 0 || fifo_count != 0) && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("drain_empty", {inflight, fifo_count}, 0);
    check("drain_sb", exp_q.size(), 0);
  endtask
  task automatic run_vec(input int id, input logic [127:0] st, input logic [255:0] key, input logic [127:0] expd);
    int c = 0, lat = 0;
    logic acc = 0;
    tick();
    req_state[128*id +: 128] = st;
    req_key[256*id +: 256] = key;
    req_valid[id] = 1;
    while (!acc && c < 50) begin
      @(negedge clk);
      acc = req_ready[id];
      c++;
    end
    check("vec_accept", acc, 1);
    tick();
    req_valid[id] = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 100);
    check("vec_latency", lat, L + 1);
    check("vec_data", rsp_data, expd);
    check("vec_id", rsp_id, id);
  endtask
  typedef struct {
    int id;
    logic [127:0] st;
    logic [255:0] key;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [4];
  initial begin
    int h0, c;
    vt[0] = '{0, FPT, FKEY, FCT};
    vt[1] = '{3, 128'h0, 256'h0, 128'h0};
    vt[2] = '{1, {128{1'b1}}, 256'h0, {128{1'b1}}};
    vt[3] = '{2, 128'h1, {64'h0, 64'h2, 64'h0, 64'h4}, {64'h2, 64'h5}};
    all_valid();
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_core_state", core_state, 0);
    check("rst_core_key", core_key, 0);
    check("rst_inflight", inflight, 0);
    check("rst_fifo_count", fifo_count, 0);
    req_valid = '0;
    rsp_ready = 1;
    tick();
    rst = 0;
    for (int v = 0; v < 4; v++) run_vec(vt[v].id, vt[v].st, vt[v].key, vt[v].exp);
    drain();
    // full-rate round robin from a fresh pointer
    rst = 1;
    tick();
    rst = 0;
    g_log.delete();
    h0 = hs_total;
    all_valid();
    repeat (40) begin
      tick();
      refresh();
    end
    check("rr_throughput", hs_total - h0, 40);
    for (int k = 0; k < 8; k++) check("rr_order", g_log[k], k % NREQ);
    @(negedge clk);
    check("rr_inflight_sat", inflight, L);
    check("rr_fifo_steady", fifo_count, 1);
    drain();
    // credit limit with a stalled consumer
    rsp_ready = 0;
    h0 = hs_total;
    all_valid();
    repeat (80) begin
      tick();
      refresh();
    end
    check("credit_accepted", hs_total - h0, FD);
    @(negedge clk);
    check("credit_ready_low", req_ready, 0);
    check("credit_fifo_full", fifo_count, FD);
    check("credit_inflight", inflight, 0);
    tick();
    rsp_ready = 1;
    @(negedge clk);
    check("credit_no_same_cycle", req_ready, 0);
    tick();
    rsp_ready = 0;
    @(negedge clk);
    check("credit_one_grant", $countones(req_ready), 1);
    tick();
    req_valid = '0;
    check("credit_total", hs_total - h0, FD + 1);
    repeat (L-1) tick();
    rsp_ready = 1;
    @(negedge clk);
    check("pushpop_pre_count", fifo_count, FD - 1);
    check("pushpop_pre_inflight", inflight, 1);
    tick();
    rsp_ready = 0;
    @(negedge clk);
    check("pushpop_count", fifo_count, FD - 1);
    check("pushpop_inflight", inflight, 0);
    drain();
    // reset with blocks in the core and in the FIFO
    rsp_ready = 0;
    h0 = hs_total;
    tick();
    all_valid();
    c = 0;
    while (c < 40) begin
      tick();
      refresh();
      c++;
      if (hs_total - h0 >= 15) break;
    end
    req_valid = '0;
    c = 0;
    while (fifo_count != 5 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("mid_fifo_count", fifo_count, 5);
    check("mid_inflight", inflight, 10);
    rst = 1;
    req_valid = '1;
    #1;
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 0);
    check("mid_rst_rsp_id", rsp_id, 0);
    check("mid_rst_core_state", core_state, 0);
    check("mid_rst_core_key", core_key, 0);
    check("mid_rst_inflight", inflight, 0);
    check("mid_rst_fifo_count", fifo_count, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    rsp_ready = 1;
    c = 0;
    repeat (L + 5) begin
      @(negedge clk);
      if (rsp_valid) c++;
    end
    check("post_rst_no_garbage", c, 0);
    check("post_rst_sb_empty", exp_q.size(), 0);
    run_vec(vt[3].id, vt[3].st, vt[3].key, vt[3].exp);
    drain();
    // a late second requester alternates with the first
    g_log.delete();
    tick();
    req_state[128*2 +: 128] = r128();
    req_state[128*1 +: 128] = r128();
    req_valid = 4'b0100;
    repeat (4) begin
      tick();
      refresh();
    end
    req_valid[1] = 1;
    repeat (8) begin
      tick();
      refresh();
    end
    req_valid = '0;
    check("alt_grants", g_log.size(), 12);
    for (int k = 0; k < 12 && k < g_log.size(); k++)
      check("alt_order", g_log[k], k < 4 ? 2 : (k % 2 == 0 ? 1 : 2));
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
